// File: rtl/maze_pkg.sv
// Shared definitions for the maze memory arbiter: widths, states, port indices.
package maze_pkg;

   localparam int ADDR_W = 8;   // 16x16 maze cells
   localparam int DATA_W = 1;   // wall/visited bit

   // Port indices, also used as the read-response tag.
   localparam logic PORT_SOLVER = 1'b0;
   localparam logic PORT_HOST   = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/maze_rsp_router.sv
// Holds the one-deep read-response pipeline stage and steers the returned
// memory data to the port that issued the read.
module maze_rsp_router #(
   parameter int DATA_W = maze_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_issue,
   input  logic              rd_tag,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1
);
   import maze_pkg::*;

   logic rsp_valid;
   logic rsp_tag;

   // Remember whether a read went out this cycle and for whom; reset drops it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_tag   <= PORT_SOLVER;
      end else begin
         rsp_valid <= rd_issue;
         rsp_tag   <= rd_tag;
      end
   end

   // Demux the response; data is forced to zero whenever it is not valid.
   always_comb begin
      rvalid0 = rsp_valid & (rsp_tag == PORT_SOLVER);
      rvalid1 = rsp_valid & (rsp_tag == PORT_HOST);
      rdata0  = rvalid0 ? mem_dout : '0;
      rdata1  = rvalid1 ? mem_dout : '0;
   end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single maze memory.
// Port 0 is the solver controller, port 1 the host loader/inspector.
//
// Handshake: a requester raises reqx together with wrx/addrx/wdatax and holds
// all of them stable until a cycle in which gntx is high; the access goes to
// the memory at the end of that cycle. A read answers with a one-cycle rvalidx
// pulse exactly one cycle later; there is no back-pressure on responses.
//
// Ownership: a port keeps the memory for back-to-back accesses and hands it
// over after MAX_BURST grants if the other port is waiting, without a dead
// cycle. Coming out of IDLE costs one arbitration cycle.
module maze_mem_arbiter #(
   parameter int ADDR_W    = maze_pkg::ADDR_W,
   parameter int DATA_W    = maze_pkg::DATA_W,
   parameter int MAX_BURST = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  wr0,
   input  logic [ADDR_W-1:0]     addr0,
   input  logic [DATA_W-1:0]     wdata0,
   output logic                  gnt0,
   output logic                  rvalid0,
   output logic [DATA_W-1:0]     rdata0,
   input  logic                  req1,
   input  logic                  wr1,
   input  logic [ADDR_W-1:0]     addr1,
   input  logic [DATA_W-1:0]     wdata1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_W-1:0]     rdata1,
   output logic [ADDR_W-1:0]     mem_loc,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [DATA_W-1:0]     mem_din,
   input  logic [DATA_W-1:0]     mem_dout,
   output logic                  busy,
   output maze_pkg::arb_state_t  dbg_state
);
   import maze_pkg::*;

   localparam int              BW        = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);

   arb_state_t     state, state_nx;
   logic           rr_last, rr_last_nx;
   logic [BW-1:0]  burst_cnt, burst_nx;
   logic [BW-1:0]  burst_inc;
   logic           rd_tag;

   // Grant count of the current owner after one more grant, pinned at MAX_BURST.
   always_comb begin
      burst_inc = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + BW'(1);
   end

   // State register; reset favours port 0 by pretending port 1 went last.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rr_last   <= PORT_HOST;
         burst_cnt <= '0;
      end else begin
         state     <= state_nx;
         rr_last   <= rr_last_nx;
         burst_cnt <= burst_nx;
      end
   end

   // Next ownership: round-robin from IDLE, burst handover, release on idle.
   always_comb begin
      state_nx   = state;
      rr_last_nx = rr_last;
      burst_nx   = burst_cnt;
      case (state)
         IDLE: begin
            burst_nx = '0;
            if (req0 && req1) begin
               state_nx = (rr_last == PORT_SOLVER) ? OWN1 : OWN0;
            end else if (req0) begin
               state_nx = OWN0;
            end else if (req1) begin
               state_nx = OWN1;
            end
         end
         OWN0: begin
            if (req0) begin
               rr_last_nx = PORT_SOLVER;
               if ((burst_inc == BURST_MAX) && req1) begin
                  state_nx = OWN1;
                  burst_nx = '0;
               end else begin
                  burst_nx = burst_inc;
               end
            end else begin
               burst_nx = '0;
               state_nx = req1 ? OWN1 : IDLE;
            end
         end
         OWN1: begin
            if (req1) begin
               rr_last_nx = PORT_HOST;
               if ((burst_inc == BURST_MAX) && req0) begin
                  state_nx = OWN0;
                  burst_nx = '0;
               end else begin
                  burst_nx = burst_inc;
               end
            end else begin
               burst_nx = '0;
               state_nx = req0 ? OWN0 : IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
            burst_nx = '0;
         end
      endcase
   end

   // Access mux: the owning port drives the memory pins directly.
   always_comb begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      mem_loc = '0;
      mem_din = '0;
      rd_tag  = PORT_SOLVER;
      case (state)
         OWN0: begin
            gnt0    = req0;
            mem_rd  = req0 & ~wr0;
            mem_wr  = req0 & wr0;
            mem_loc = addr0;
            mem_din = wdata0;
         end
         OWN1: begin
            gnt1    = req1;
            mem_rd  = req1 & ~wr1;
            mem_wr  = req1 & wr1;
            mem_loc = addr1;
            mem_din = wdata1;
            rd_tag  = PORT_HOST;
         end
         default: ;
      endcase
      busy      = (state != IDLE);
      dbg_state = state;
   end

   maze_rsp_router #(.DATA_W(DATA_W)) u_rsp (
      .clk      (clk),
      .rst      (rst),
      .rd_issue (mem_rd),
      .rd_tag   (rd_tag),
      .mem_dout (mem_dout),
      .rvalid0  (rvalid0),
      .rvalid1  (rvalid1),
      .rdata0   (rdata0),
      .rdata1   (rdata1)
   );

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Bench for maze_mem_arbiter: behavioural memory, per-port requester tasks,
// reference memory image feeding per-port expected-read queues, and a
// response monitor that pops and compares independently of the drivers.
module tb_maze_mem_arbiter;
   import maze_pkg::*;

   localparam int AW   = 8;
   localparam int DW   = 1;
   localparam int MAXB = 4;
   localparam int TMO  = 50;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic          req_v [2];
   logic          wr_v  [2];
   logic [AW-1:0] addr_v[2];
   logic [DW-1:0] wdata_v[2];

   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] mem_loc;
   logic          mem_rd, mem_wr, busy;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout = '0;
   arb_state_t    dbg_state;

   maze_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst),
      .req0(req_v[0]), .wr0(wr_v[0]), .addr0(addr_v[0]), .wdata0(wdata_v[0]),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req_v[1]), .wr1(wr_v[1]), .addr1(addr_v[1]), .wdata1(wdata_v[1]),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_loc(mem_loc), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din),
      .mem_dout(mem_dout), .busy(busy), .dbg_state(dbg_state)
   );

   // ---------------- maze memory (environment) ----------------
   logic [DW-1:0] bmem[2**AW];
   logic          poke_en = 1'b0;
   logic [AW-1:0] poke_a  = '0;
   logic [DW-1:0] poke_d  = '0;

   always @(posedge clk) begin
      if (poke_en) bmem[poke_a] <= poke_d;
      else begin
         if (mem_wr) bmem[mem_loc] <= mem_din;
         if (mem_rd) mem_dout <= bmem[mem_loc];
      end
   end

   // ---------------- reference model / scoreboard ----------------
   logic [DW-1:0] ref_mem[2**AW];
   logic [DW-1:0] exp_q0[$];
   logic [DW-1:0] exp_q1[$];
   int            rd_now = -1, rd_prev = -1;
   bit            in_reset = 1'b1;
   int            rv_cnt[2];
   int            max_wait = 0;
   int            gl_port[$];
   int            gl_cyc[$];
   int            n_cmp = 0, n_bad = 0;

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            gap;
   } xact_t;
   xact_t sq0[$];
   xact_t sq1[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
      poke_en = 1'b1; poke_a = a; poke_d = d;
      ref_mem[a] = d;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in_reset = 1'b1;
      exp_q0.delete();
      exp_q1.delete();
      rd_now = -1;
      rd_prev = -1;
   endtask

   task automatic release_reset();
      rst = 1'b1;
      in_reset = 1'b0;
   endtask

   // Called at the sampling point of a cycle in which port p is granted.
   task automatic note_grant(input int p, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
      chk($sformatf("gnt_other_p%0d", p), 32'(p == 0 ? gnt1 : gnt0), 32'd0);
      chk($sformatf("mem_loc_p%0d", p), 32'(mem_loc), 32'(a));
      chk($sformatf("mem_rd_p%0d", p), 32'(mem_rd), 32'(!w));
      chk($sformatf("mem_wr_p%0d", p), 32'(mem_wr), 32'(w));
      chk($sformatf("mem_din_p%0d", p), 32'(mem_din), 32'(d));
      chk($sformatf("busy_grant_p%0d", p), 32'(busy), 32'd1);
      chk($sformatf("state_grant_p%0d", p), 32'(dbg_state), 32'(p == 0 ? OWN0 : OWN1));
      if (w) ref_mem[a] = d;
      else begin
         if (p == 0) exp_q0.push_back(ref_mem[a]);
         else        exp_q1.push_back(ref_mem[a]);
         rd_now = p;
      end
      gl_port.push_back(p);
      gl_cyc.push_back(cyc);
   endtask

   // Present one request and hold it until granted; returns the number of
   // sampled cycles without a grant. Leaves req high; caller decides next.
   task automatic do_xact(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int waited);
      bit got;
      req_v[p] = 1'b1; wr_v[p] = w; addr_v[p] = a; wdata_v[p] = d;
      waited = 0;
      got = 1'b0;
      while (!got && waited <= TMO) begin
         @(negedge clk);
         if ((p == 0) ? gnt0 : gnt1) got = 1'b1;
         else waited++;
      end
      if (!got) begin
         chk($sformatf("grant_timeout_p%0d", p), 32'd0, 32'd1);
         req_v[p] = 1'b0;
      end else begin
         note_grant(p, w, a, d);
         if (waited > max_wait) max_wait = waited;
      end
      @(posedge clk); #1;
   endtask

   task automatic run_port(input int p);
      xact_t x;
      int    w;
      while ((p == 0 ? sq0.size() : sq1.size()) > 0) begin
         if (p == 0) x = sq0.pop_front();
         else        x = sq1.pop_front();
         if (x.gap > 0) begin
            req_v[p] = 1'b0;
            idle(x.gap);
         end
         do_xact(p, x.w, x.a, x.d, w);
      end
      req_v[p] = 1'b0;
   endtask

   task automatic clear_log();
      gl_port.delete();
      gl_cyc.delete();
      rv_cnt[0] = 0;
      rv_cnt[1] = 0;
      max_wait = 0;
   endtask

   task automatic drained(input string tag);
      chk({tag, "_q0_drained"}, 32'(exp_q0.size()), 32'd0);
      chk({tag, "_q1_drained"}, 32'(exp_q1.size()), 32'd0);
   endtask

   // ---------------- response monitor ----------------
   task automatic mon_port(input int p, input logic rv, input logic [DW-1:0] rd);
      logic [DW-1:0] e;
      bit            exp_rv;
      exp_rv = (rd_prev == p);
      if (rv || exp_rv) chk($sformatf("rvalid%0d_timing", p), 32'(rv), 32'(exp_rv));
      if (rv) begin
         rv_cnt[p]++;
         if ((p == 0 ? exp_q0.size() : exp_q1.size()) == 0)
            chk($sformatf("rvalid%0d_unexpected", p), 32'd1, 32'd0);
         else begin
            if (p == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            chk($sformatf("rdata%0d", p), 32'(rd), 32'(e));
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (in_reset) begin
            rd_now = -1;
            rd_prev = -1;
         end else begin
            mon_port(0, rvalid0, rdata0);
            mon_port(1, rvalid1, rdata1);
            rd_prev = rd_now;
            rd_now = -1;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int w;
      int exp_seq[$];
      int r[2];
      int cur, k;
      int seen[2];
      bit ok;

      for (int i = 0; i < 2; i++) begin
         req_v[i] = 1'b0; wr_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
         rv_cnt[i] = 0;
      end
      rst = 1'b0;
      in_reset = 1'b1;
      @(posedge clk); #1;

      // Reset state, with both requesters active to show nothing leaks through.
      req_v[0] = 1'b1; req_v[1] = 1'b1; wr_v[1] = 1'b1;
      addr_v[0] = 8'h5A; addr_v[1] = 8'hA5; wdata_v[1] = 1'b1;
      @(negedge clk);
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_loc", 32'(mem_loc), 32'd0);
      chk("rst_mem_din", 32'(mem_din), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rvalid0", 32'(rvalid0), 32'd0);
      chk("rst_rvalid1", 32'(rvalid1), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      req_v[0] = 1'b0; req_v[1] = 1'b0; wr_v[1] = 1'b0;

      // Fill the maze memory with random cells while the arbiter is held.
      for (int i = 0; i < 2**AW; i++) poke(AW'(i), DW'($urandom_range(0, 1)));
      poke(8'h23, 1'b1);
      poke(8'h40, 1'b1);
      release_reset();
      idle(2);

      // Single read from idle: one arbitration cycle, then grant, then data.
      clear_log();
      req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 8'h23;
      @(negedge clk);
      chk("t2_arb_gnt0", 32'(gnt0), 32'd0);
      chk("t2_arb_busy", 32'(busy), 32'd0);
      do_xact(0, 1'b0, 8'h23, 1'b0, w);
      chk("t2_grant_wait", 32'(w), 32'd0);
      req_v[0] = 1'b0;
      idle(3);
      chk("t2_rvalid0_count", 32'(rv_cnt[0]), 32'd1);
      chk("t2_rvalid1_count", 32'(rv_cnt[1]), 32'd0);
      drained("t2");

      // Reset arriving right after a read is issued: response must vanish.
      do_xact(0, 1'b0, 8'h40, 1'b0, w);
      chk("t1_idle_latency", 32'(w), 32'd1);
      do_reset();
      @(negedge clk);
      chk("t1_rvalid0", 32'(rvalid0), 32'd0);
      chk("t1_gnt0", 32'(gnt0), 32'd0);
      chk("t1_mem_rd", 32'(mem_rd), 32'd0);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_mem_loc", 32'(mem_loc), 32'd0);
      @(posedge clk); #1;
      release_reset();
      clear_log();
      do_xact(0, 1'b0, 8'h40, 1'b0, w);
      chk("t1_post_reset_latency", 32'(w), 32'd1);
      req_v[0] = 1'b0;
      idle(3);
      chk("t1_rvalid0_count", 32'(rv_cnt[0]), 32'd1);
      drained("t1");

      // Simultaneous first request, one access per request: grants alternate.
      do_reset(); idle(1); release_reset();
      clear_log();
      for (int i = 0; i < 3; i++) begin
         sq0.push_back('{1'b0, AW'($urandom_range(0, 255)), 1'b0, (i == 0) ? 0 : 1});
         sq1.push_back('{1'b0, AW'($urandom_range(0, 255)), 1'b0, (i == 0) ? 0 : 1});
      end
      fork
         run_port(0);
         run_port(1);
      join
      idle(3);
      chk("t3_grants", 32'(gl_port.size()), 32'd6);
      for (int i = 0; i < gl_port.size(); i++) chk($sformatf("t3_order_%0d", i), 32'(gl_port[i]), 32'(i % 2));
      drained("t3");

      // Burst limit: both ports stream 10 reads each.
      do_reset(); idle(1); release_reset();
      clear_log();
      for (int i = 0; i < 10; i++) begin
         sq0.push_back('{1'b0, AW'($urandom_range(0, 255)), 1'b0, 0});
         sq1.push_back('{1'b0, AW'($urandom_range(0, 255)), 1'b0, 0});
      end
      fork
         run_port(0);
         run_port(1);
      join
      idle(3);
      // Expected owner sequence: chunks of MAXB while the other still wants
      // the memory, then the remainder, starting with port 0.
      exp_seq.delete();
      r[0] = 10; r[1] = 10; cur = 0;
      while (r[0] + r[1] > 0) begin
         if (r[cur] == 0) cur = 1 - cur;
         k = (r[1 - cur] > 0) ? ((r[cur] < MAXB) ? r[cur] : MAXB) : r[cur];
         repeat (k) exp_seq.push_back(cur);
         r[cur] -= k;
         cur = 1 - cur;
      end
      chk("t4_grants", 32'(gl_port.size()), 32'(exp_seq.size()));
      seen[0] = 0; seen[1] = 0;
      for (int i = 0; i < exp_seq.size() && i < gl_port.size(); i++) begin
         chk($sformatf("t4_order_%0d", i), 32'(gl_port[i]), 32'(exp_seq[i]));
         if (i > 0) begin
            // A handover only costs a cycle when the previous owner is finished.
            if (!(seen[gl_port[i-1]] == 10 && gl_port[i] != gl_port[i-1]))
               chk($sformatf("t4_back_to_back_%0d", i), 32'(gl_cyc[i] - gl_cyc[i-1]), 32'd1);
         end
         seen[gl_port[i]]++;
      end
      drained("t4");

      // Solo streaming: 10 reads at 0..9, no gaps, responses in order.
      do_reset(); idle(1); release_reset();
      clear_log();
      for (int i = 0; i < 10; i++) sq0.push_back('{1'b0, AW'(i), 1'b0, 0});
      run_port(0);
      idle(3);
      chk("t5_grants", 32'(gl_port.size()), 32'd10);
      ok = 1'b1;
      for (int i = 1; i < gl_cyc.size(); i++) if (gl_cyc[i] - gl_cyc[i-1] != 1) ok = 1'b0;
      chk("t5_back_to_back", 32'(ok), 32'd1);
      chk("t5_rvalid0_count", 32'(rv_cnt[0]), 32'd10);
      drained("t5");

      // Host writes 1 to 0xFF, solver then reads it back.
      poke(8'hFF, 1'b0);
      clear_log();
      sq1.push_back('{1'b1, 8'hFF, 1'b1, 0});
      sq0.push_back('{1'b0, 8'hFF, 1'b0, 1});
      fork
         run_port(0);
         run_port(1);
      join
      idle(3);
      chk("t6_order_first", 32'(gl_port.size() > 0 ? gl_port[0] : 9), 32'd1);
      chk("t6_rvalid1_count", 32'(rv_cnt[1]), 32'd0);
      chk("t6_rvalid0_count", 32'(rv_cnt[0]), 32'd1);
      chk("t6_ref_cell", 32'(ref_mem[8'hFF]), 32'd1);
      drained("t6");

      // Random mixed traffic on a small address window to force conflicts.
      do_reset(); idle(1); release_reset();
      clear_log();
      for (int i = 0; i < 40; i++) begin
         sq0.push_back('{1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                         DW'($urandom_range(0, 1)), $urandom_range(0, 2)});
         sq1.push_back('{1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                         DW'($urandom_range(0, 1)), $urandom_range(0, 2)});
      end
      fork
         run_port(0);
         run_port(1);
      join
      idle(4);
      chk("rand_grants", 32'(gl_port.size()), 32'd80);
      chk("rand_wait_bounded", 32'(max_wait <= MAXB + 2), 32'd1);
      drained("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/maze_mem_arbiter.md
Name: maze_mem_arbiter

Overview:
Two-port arbiter that shares the single maze memory between the solver controller (port 0) and a host maze loader/inspector (port 1).
- Round-robin selection between ports, with bounded burst ownership.
- Issues one memory access per cycle to the memory's loc/rd/wr/dIn pins.
- Returns synchronous read data to the owning port one cycle after issue.
- Sits between the controller/loader and the maze memory in the top-level maze solver.

Parameters:
ADDR_W, 8, memory address width (16x16 maze cells).
DATA_W, 1, cell data width (wall/visited bit).
MAX_BURST, 4, max consecutive grants to one port while the other port is requesting; must be ≥1.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset; asynchronous, active-low.
req0  in  1  port 0 request; held with wr0/addr0/wdata0 stable until gnt0.
wr0  in  1  port 0: 1 = write, 0 = read.
addr0  in  ADDR_W  port 0 cell address.
wdata0  in  DATA_W  port 0 write data.
gnt0  out  1  port 0 access issued this cycle.
rvalid0  out  1  port 0 read data valid.
rdata0  out  DATA_W  port 0 read data.
req1, wr1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
mem_loc  out  ADDR_W  memory address.
mem_rd  out  1  memory read strobe.
mem_wr  out  1  memory write strobe.
mem_din  out  DATA_W  memory write data.
mem_dout  in  DATA_W  memory read data; valid the cycle after mem_rd.
busy  out  1  high when state ≠ IDLE.

Behaviour:
- States: IDLE, OWN0, OWN1. Registers: state, rr_last (last owner), burst_cnt (width clog2(MAX_BURST+1)), rsp_valid, rsp_tag.
- Reset (rst=0, async) forces:
  - state=IDLE, rr_last=1 (port 0 favoured), burst_cnt=0, rsp_valid=0.
  - gnt*, rvalid*, mem_rd, mem_wr = 0; mem_loc=0, mem_din=0, busy=0.
  - An in-flight read response is dropped, never delivered.
- IDLE:
  - No access is issued.
  - Only one req → OWN of that port.
  - Both req → OWN of the port ≠ rr_last.
  - Neither → stay IDLE.
  - burst_cnt := 0.
  - Consequence: first access after idle has 1-cycle arbitration latency.
- OWNx, access path (combinational, qualified by state):
  - gntx = reqx.
  - mem_rd = reqx & ~wrx; mem_wr = reqx & wrx.
  - mem_loc = addrx, mem_din = wdatax.
  - The other port's gnt = 0. Outside OWN states, mem_loc/mem_din = 0.
- OWNx, on a grant:
  - burst_cnt saturating-increments; rr_last := x.
  - If burst_cnt reaches MAX_BURST and the other port is requesting → next state OWN_other with burst_cnt := 0; no dead cycle.
  - Otherwise stay OWNx and keep issuing back-to-back.
- OWNx, reqx low: no issue; next state is OWN_other if the other port is requesting (burst_cnt := 0), else IDLE.
- Read return: on an issued read, rsp_valid := 1 and rsp_tag := x on the next edge. rvalid<tag> = rsp_valid. rdata0 = rdata1 = mem_dout (qualified only by rvalid). Writes produce no rvalid.
- Pipelining:
  - Read issued in cycle N → rvalid in N+1, regardless of an ownership change in N+1.
  - Read issued in N+1 → its rvalid in N+2; one response per cycle max.
- Simultaneous write and read to the same address in consecutive cycles: the read sees the written value (memory write-then-read ordering).
- Requester contract: a request must not be withdrawn before its grant. Behaviour under an address change while waiting is unspecified.

Decomposition:
- Shared package maze_pkg holds:
  - ADDR_W and DATA_W constants.
  - arb_state_t enum (IDLE, OWN0, OWN1).
  - Port-index constants PORT_SOLVER=0 and PORT_HOST=1.
- One sub-module, maze_rsp_router: registers rsp_valid/rsp_tag, demuxes rvalid0/rvalid1, clears on reset.
- FSM, burst counter and access mux stay in the top module.

Test Plan:
1. Reset mid-read: port 0 read issued, then rst=0 the next cycle → rvalid0 stays 0; gnt0/gnt1/mem_rd/mem_wr/busy = 0; after release, the first grant comes 1 cycle after req.
2. Single read: req0=1, wr0=0, addr0=0x23, cell=1 → cycle1 state OWN0; cycle2 gnt0=1, mem_rd=1, mem_loc=0x23; cycle3 rvalid0=1, rdata0=1, rvalid1=0.
3. Simultaneous first request: req0 and req1 rise together out of reset → port 0 granted first. Both re-request after one access each → grants alternate 0,1,0,1.
4. Burst limit: req0 held for 10 reads, req1 asserted throughout → exactly 4 gnt0 pulses, then gnt1 the very next cycle, then back to port 0 after 4 port-1 grants.
5. Solo streaming: only req0 held for 10 reads at addresses 0..9 → 10 consecutive gnt0 with no gap, 10 consecutive rvalid0 one cycle delayed, in address order.
6. Write then cross-port read: port 1 writes 1 to 0xFF (gnt1, mem_wr=1, no rvalid1), then port 0 reads 0xFF → rdata0=1 with rvalid0=1.
